// File: rtl/envelope_config_scheduler.sv
// Envelope config-write scheduler: two requesters, round-robin arbitration, a small
// FIFO, and a one-hot write strobe held off while the head targets the live operator.
module envelope_config_scheduler #(
  parameter int OP_ID_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_HostValid,
  output logic                   o_HostReady,
  input  logic [2:0]             i_HostField,
  input  logic [OP_ID_WIDTH-1:0] i_HostAddr,
  input  logic [15:0]            i_HostData,
  input  logic                   i_LoadValid,
  output logic                   o_LoadReady,
  input  logic [2:0]             i_LoadField,
  input  logic [OP_ID_WIDTH-1:0] i_LoadAddr,
  input  logic [15:0]            i_LoadData,
  input  logic [OP_ID_WIDTH-1:0] i_VoiceOperator,
  input  logic                   i_ErrorClear,
  output logic [4:0]             o_EnvelopeConfigWriteEnable,
  output logic [OP_ID_WIDTH-1:0] o_ConfigWriteAddr,
  output logic [15:0]            o_ConfigWriteData,
  output logic                   o_Busy,
  output logic                   o_FieldError
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [2:0]             field;
    logic [OP_ID_WIDTH-1:0] addr;
    logic [15:0]            data;
  } entry_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  entry_t                 mem_q [FIFO_DEPTH];
  entry_t                 mem_d [FIFO_DEPTH];
  logic                   rr_q, rr_d;
  logic [4:0]             we_q, we_d;
  logic [OP_ID_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]            data_q, data_d;
  logic                   err_q, err_d;

  logic   not_full, host_gnt, load_gnt, host_acc, load_acc, accept, field_ok, push, pop;
  entry_t req, head;

  // rr_q high means the host won last, so the loader takes the next tie.
  assign not_full = (count_q < CW'(FIFO_DEPTH));
  assign host_gnt = i_HostValid & (~i_LoadValid | ~rr_q);
  assign load_gnt = i_LoadValid & (~i_HostValid | rr_q);

  assign o_HostReady = i_Reset_n & not_full & host_gnt;
  assign o_LoadReady = i_Reset_n & not_full & load_gnt;

  assign host_acc = i_HostValid & o_HostReady;
  assign load_acc = i_LoadValid & o_LoadReady;
  assign accept   = host_acc | load_acc;

  always_comb begin
    req = '0;
    if (host_acc) req = '{field: i_HostField, addr: i_HostAddr, data: i_HostData};
    else          req = '{field: i_LoadField, addr: i_LoadAddr, data: i_LoadData};
  end

  assign field_ok = (req.field <= 3'd4);
  assign push     = accept & field_ok;
  assign head     = mem_q[rd_ptr_q];
  // Never pop into the operator currently being attenuated.
  assign pop      = (count_q != '0) & (head.addr != i_VoiceOperator);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rr_d     = rr_q;
    we_d     = '0;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];

    if (accept) rr_d = host_acc;

    if (push) begin
      mem_d[wr_ptr_q] = req;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      we_d     = 5'b00001 << head.field;
      addr_d   = head.addr;
      data_d   = head.data;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set wins over clear.
    if (accept && !field_ok) err_d = 1'b1;
    else if (i_ErrorClear)   err_d = 1'b0;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rr_q     <= 1'b0;
      we_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rr_q     <= rr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: count and pointers define what is valid.
  always_ff @(posedge i_Clock) begin
    for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign o_EnvelopeConfigWriteEnable = we_q;
  assign o_ConfigWriteAddr           = addr_q;
  assign o_ConfigWriteData           = data_q;
  assign o_FieldError                = err_q;
  assign o_Busy                      = (count_q != '0) | (we_q != '0);

endmodule

// File: doc/envelope_config_scheduler.md
ENVELOPE_CONFIG_SCHEDULER -- requirements
Module: envelope_config_scheduler

Interface
REQ-001 SHALL have parameter OP_ID_WIDTH, default 8, width of voice-operator address.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of buffered config writes (power of two).
REQ-003 SHALL have port i_Clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_HostValid input 1, o_HostReady output 1, i_HostField input 3, i_HostAddr input OP_ID_WIDTH, i_HostData input 16: host config-write requester.
REQ-006 SHALL have ports i_LoadValid input 1, o_LoadReady output 1, i_LoadField input 3, i_LoadAddr input OP_ID_WIDTH, i_LoadData input 16: patch-loader requester.
REQ-007 SHALL have port i_VoiceOperator  input  OP_ID_WIDTH  voice-operator currently entering the envelope attenuator.
REQ-008 SHALL have port i_ErrorClear  input  1  clears o_FieldError.
REQ-009 SHALL have port o_EnvelopeConfigWriteEnable  output  5  one-hot write strobe: bit0 attack level, bit1 sustain level, bit2 attack rate, bit3 decay rate, bit4 release rate.
REQ-010 SHALL have ports o_ConfigWriteAddr output OP_ID_WIDTH and o_ConfigWriteData output 16: write target and payload.
REQ-011 SHALL have port o_Busy  output  1  high while FIFO non-empty or strobe active.
REQ-012 SHALL have port o_FieldError  output  1  sticky flag, invalid field code accepted.

Function
REQ-013 SHALL accept a request from a requester in a cycle where its Valid and Ready are both high; at most one acceptance per cycle.
REQ-014 SHALL drive Ready combinationally: Ready high only if FIFO count < FIFO_DEPTH and the arbiter grants that requester.
REQ-015 SHALL arbitrate round-robin: one requester valid -> it is granted; both valid -> requester not accepted most recently is granted; pointer updates only on acceptance.
REQ-016 SHALL treat full as blocking: no acceptance when count == FIFO_DEPTH, even if a pop occurs in the same cycle.
REQ-017 SHALL push accepted requests with field 0-4 into FIFO as {field, addr, data}.
REQ-018 SHALL complete the handshake for field 5-7 but not push, and set o_FieldError next cycle; o_FieldError stays high until i_ErrorClear high (set wins over clear in same cycle).
REQ-019 SHALL pop the head entry in a cycle where FIFO non-empty and head addr != i_VoiceOperator (collision hold-off); otherwise head waits.
REQ-020 SHALL, in the cycle after a pop, drive o_EnvelopeConfigWriteEnable = 1 << field for exactly one cycle, with o_ConfigWriteAddr/o_ConfigWriteData = popped entry.
REQ-021 SHALL drive o_EnvelopeConfigWriteEnable = 0 in every cycle not following a pop; addr/data hold last issued values.
REQ-022 SHALL allow push and pop in the same cycle when 0 < count < FIFO_DEPTH, count unchanged.
REQ-023 SHALL only pop stored entries: minimum latency accept -> strobe is 2 cycles; no bypass from empty.
REQ-024 SHALL issue writes in acceptance order; pointers wrap modulo FIFO_DEPTH.
REQ-025 SHALL pop at most one entry per cycle, giving at most one strobe bit set per cycle.

Reset
REQ-026 SHALL, while i_Reset_n low, asynchronously clear FIFO count and pointers, o_EnvelopeConfigWriteEnable, o_ConfigWriteAddr, o_ConfigWriteData, o_FieldError, o_Busy to 0.
REQ-027 SHALL reset round-robin pointer so host wins first tie.
REQ-028 SHALL discard buffered entries and any pending strobe on reset mid-operation; no strobe in first cycle after release.
REQ-029 SHALL hold Ready outputs low while i_Reset_n low.

Verification
REQ-030 Host writes field 3, addr 0x12, data 0x0ABC, i_VoiceOperator != 0x12 -> enable 5'b01000, addr 0x12, data 0x0ABC, one cycle, 2 cycles after acceptance.
REQ-031 Both requesters valid continuously after reset -> grants host, loader, host, loader; writes issued in that order.
REQ-032 Loader pushes 5 entries while i_VoiceOperator matches head addr -> 4 accepted, o_LoadReady low on 5th until first pop; all 5 strobes appear in order after i_VoiceOperator changes.
REQ-033 Host field 6 -> handshake completes, no strobe, o_FieldError high next cycle and held until i_ErrorClear pulse.
REQ-034 Reset asserted with 3 entries queued -> outputs 0 immediately, no strobes after release, o_Busy 0.
REQ-035 Simultaneous push and pop at count 2 -> count stays 2, order preserved.
